// File: rtl/ufp_div_seq_pkg.sv
// Shared fp_core definitions for the sequential ufp divider: FSM states,
// default format widths and small elaboration-time helpers.
package ufp_div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int UFP_WL = 16;
   localparam int UFP_QW = 8;

   // Counter width needed to count WL+QW quotient iterations.
   function automatic int cnt_w(input int wl, input int qw);
      return $clog2(wl + qw);
   endfunction

   // Saturation pattern: the low w bits set.
   function automatic logic [63:0] all_ones(input int w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

endpackage

// File: rtl/ufp_div_seq_if.sv
// Unsigned fixed-point word carrier; producers drive val, consumers read it.
interface ufp_if #(parameter int WL = 16);

   logic [WL-1:0] val;

   modport in  (input  val);
   modport out (output val);

endinterface

// File: rtl/ufp_div_seq_step.sv
// One restoring radix-2 division step: shift in a dividend bit, subtract the
// divisor when it fits and emit the resulting quotient bit.
module ufp_div_step #(
   parameter int WL = 16
) (
   input  logic [WL:0]   i_rem,
   input  logic          i_bit,
   input  logic [WL-1:0] i_div,
   output logic [WL:0]   o_rem_next,
   output logic          o_qbit
);

   logic [WL+1:0] w_shift;
   logic [WL:0]   w_diff;

   // The restored remainder is always below the divisor, so the top bit of
   // the shifted value is zero and the difference fits in WL+1 bits.
   assign w_shift    = {i_rem, i_bit};
   assign o_qbit     = (w_shift >= {2'b00, i_div});
   assign w_diff     = w_shift[WL:0] - {1'b0, i_div};
   assign o_rem_next = o_qbit ? w_diff : w_shift[WL:0];

endmodule

// File: rtl/ufp_div_seq.sv
// Iterative restoring divider q = a / b in IW.QW unsigned fixed point, one
// quotient bit per cycle, with saturation and divide-by-zero flags.
module ufp_div_seq
   import ufp_div_seq_pkg::*;
#(
   parameter int WL = UFP_WL,
   parameter int IW = UFP_WL - UFP_QW,
   parameter int QW = UFP_QW
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   output logic   in_ready,
   ufp_if.in      a,
   ufp_if.in      b,
   output logic   out_valid,
   input  logic   out_ready,
   ufp_if.out     q,
   output logic   ovf,
   output logic   dz,
   output state_t o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and a result is held until taken.

   localparam int             N   = IW + QW + QW;  // IW+QW == WL
   localparam int             CW  = cnt_w(WL, QW);
   localparam logic [WL-1:0]  SAT = WL'(all_ones(WL));

   state_t         r_state, w_next;
   logic [WL:0]    r_rem;
   logic [N-2:0]   r_quo;
   logic [N-1:0]   r_dvd;
   logic [WL-1:0]  r_div;
   logic [CW-1:0]  r_cnt;
   logic [WL-1:0]  r_q;
   logic           r_ovf;
   logic           r_dz;

   logic [WL:0]    w_rem_next;
   logic           w_qbit;
   logic [N-1:0]   w_quo_full;
   logic           w_ovf;

   ufp_div_step #(.WL(WL)) u_step (
      .i_rem      (r_rem),
      .i_bit      (r_dvd[N-1]),
      .i_div      (r_div),
      .o_rem_next (w_rem_next),
      .o_qbit     (w_qbit)
   );

   assign w_quo_full = {r_quo, w_qbit};
   assign w_ovf      = |w_quo_full[N-1:WL];

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = (b.val == '0) ? DONE : DIV;
         end
         DIV: begin
            if (r_cnt == '0) w_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem <= '0;
         r_quo <= '0;
         r_dvd <= '0;
         r_div <= '0;
         r_cnt <= '0;
         r_q   <= '0;
         r_ovf <= 1'b0;
         r_dz  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (b.val == '0) begin
                     r_q   <= SAT;
                     r_ovf <= 1'b0;
                     r_dz  <= 1'b1;
                  end else begin
                     r_dvd <= {a.val, {QW{1'b0}}};
                     r_div <= b.val;
                     r_rem <= '0;
                     r_quo <= '0;
                     r_cnt <= CW'(N - 1);
                  end
               end
            end
            DIV: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_full[N-2:0];
               r_dvd <= {r_dvd[N-2:0], 1'b0};
               r_cnt <= r_cnt - CW'(1);
               // Final iteration: apply the width rule to the full quotient.
               if (r_cnt == '0) begin
                  r_q   <= w_ovf ? SAT : w_quo_full[WL-1:0];
                  r_ovf <= w_ovf;
                  r_dz  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign q.val       = r_q;
   assign ovf         = r_ovf;
   assign dz          = r_dz;
   assign o_dbg_state = r_state;

endmodule

// File: doc/ufp_div_seq.md
Name: ufp_div_seq

Overview:
Iterative radix-2 restoring divider that consumes two ufp operands and produces their ufp quotient, q = a / b, in the same IW.QW format. It sits directly downstream of the ufp producers in fp_core, such as bench-side real-to-ufp conversion and upstream arithmetic stages, and feeds the raytracer datapath. It is used where one divider per lane is too costly and a multi-cycle latency is acceptable. Valid/ready handshakes are used on both input and output.

Parameters:
WL, 16, total word length of operands and result (taken from the ufp_if instances; must match on a, b and q).
IW, 8, integer bits (IW + QW = WL).
QW, 8, fractional bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand pair a/b presented.
in_ready  out  1  block can accept operands.
a  ufp_if.in  WL  dividend.
b  ufp_if.in  WL  divisor.
out_valid  out  1  quotient q and flags valid.
out_ready  in  1  consumer accepts the result.
q  ufp_if.out  WL  quotient, truncated toward zero.
ovf  out  1  quotient saturated because it exceeds the format.
dz  out  1  divide by zero.

Behaviour:
- Reset values:
  - state = IDLE; in_ready = 1.
  - out_valid = 0; q.val = 0; ovf = 0; dz = 0.
  - Internal remainder, quotient and counter registers = 0.
- Arithmetic:
  - Exact result is floor((a.val << QW) / b.val), computed as N = WL + QW quotient bits.
  - Dividend register is N bits; remainder register is WL+1 bits.
- Iteration step:
  - rem' = {rem, next dividend bit}.
  - If rem' >= b.val: subtract b.val and shift in quotient bit 1; otherwise shift in 0.
- Width rule:
  - If any of the top QW quotient bits is 1, then q.val = all ones and ovf = 1.
  - Otherwise q.val = the low WL quotient bits and ovf = 0.
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1:
    - b.val == 0: latch q.val = all ones, dz = 1, ovf = 0; go to DONE. out_valid rises 1 cycle after accept.
    - Otherwise: latch a and b, clear rem, set count = N-1; go to DIV.
- DIV:
  - in_ready = 0; one iteration per cycle.
  - In the cycle where count == 0: perform the final iteration, register q/ovf/dz = 0, go to DONE.
  - Latency: out_valid is high exactly N cycles after the accept edge (24 with defaults).
- DONE:
  - out_valid = 1; q, ovf and dz are held stable while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE, so there is no accept in the same cycle as the result handshake. Throughput is one division per N+2 cycles.
- Input rules:
  - a and b are sampled only on the accept edge.
  - Changes on a, b or in_valid during DIV or DONE have no effect.
- Reset:
  - rst asserted in any state, including mid-DIV, forces the reset values on the next edge.
  - The in-flight operation is discarded and no out_valid pulse is produced.
- Edge cases:
  - a.val == 0 with b != 0 gives q = 0, ovf = 0, dz = 0, with full N-cycle latency.
  - a.val == b.val gives q = 1.0 = (1 << QW).

Decomposition:
- Shared fp_core package holds:
  - the FSM state enum (IDLE, DIV, DONE);
  - the helper function for the count width, clog2(WL+QW);
  - the saturation constant all-ones(WL).
- One natural sub-module, ufp_div_step: combinational single restoring iteration.
  - Inputs: rem, next bit, divisor.
  - Outputs: rem_next, qbit.
  - Instantiated once, in the DIV state datapath.

Test Plan:
1. 8.8 format: a=0x0180 (1.5), b=0x0080 (0.5), out_ready=1 -> q=0x0300 (3.0), ovf=0, dz=0; out_valid exactly 24 cycles after the accept edge.
2. a=0x0100 (1.0), b=0x0300 (3.0) -> q=0x0055 (truncated 0.33203125), ovf=0.
3. a=0xFF00 (255.0), b=0x0001 (1/256) -> q=0xFFFF, ovf=1, dz=0.
4. a=0x1234, b=0x0000 -> q=0xFFFF, dz=1, ovf=0; out_valid one cycle after accept.
5. a=0x0200, b=0x0100, out_ready held 0 for 5 cycles after out_valid, with a/b/in_valid toggled throughout -> q=0x0200 stays stable; in_ready=0 until the cycle after out_ready=1; no second accept.
6. Start a=0x0180, b=0x0080; assert rst at cycle 10 of DIV -> next cycle in_ready=1, out_valid=0, q=0. Then a=0x0100, b=0x0300 -> q=0x0055 after 24 cycles, with no stale result.
